// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register and an iterative multiply/divide
// unit writing HI/LO; stalls HI/LO consumers while the unit is busy.
module ex_stage #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegDst_in,
  input  logic        ALUSrc_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  ALUOp_in,
  input  logic [5:0]  funct_in,
  input  logic [4:0]  shamt_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] rfile_rd1_in,
  input  logic [31:0] rfile_rd2_in,
  input  logic [31:0] extend_immed_in,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] wdata_out,
  output logic [4:0]  wreg_out,
  output logic        stall,
  output logic        md_busy
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

  state_t      r_state, w_state_next;
  logic [5:0]  r_count, w_count_next;
  logic [31:0] r_acc_hi, r_acc_lo, w_acc_hi_next, w_acc_lo_next;
  logic [31:0] r_hi, r_lo, w_hi_next, w_lo_next;
  logic [31:0] r_mcand;
  logic        r_is_div, r_neg_lo, r_neg_hi, r_md_busy, w_md_busy_next;

  logic [31:0] w_b, w_result;
  logic        w_rtype, w_md_op, w_hilo_op, w_md_start, w_signed, w_sa, w_sb;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_sum, w_rem_sh;
  logic [33:0] w_diff;
  logic [63:0] w_prod;

  assign w_b        = ALUSrc_in ? extend_immed_in : rfile_rd2_in;
  assign w_rtype    = (ALUOp_in == 2'b10);
  assign w_md_op    = w_rtype && (funct_in[5:2] == 4'b0110);
  assign w_hilo_op  = w_md_op || (w_rtype && (funct_in == 6'h10 || funct_in == 6'h12));
  assign stall      = r_md_busy && w_hilo_op;
  assign md_busy    = r_md_busy;
  assign w_md_start = w_md_op && !stall;

  // Even funct codes (mult, div) are the signed variants
  assign w_signed = !funct_in[0];
  assign w_sa     = w_signed && rfile_rd1_in[31];
  assign w_sb     = w_signed && rfile_rd2_in[31];
  assign w_mag_a  = w_sa ? -rfile_rd1_in : rfile_rd1_in;
  assign w_mag_b  = w_sb ? -rfile_rd2_in : rfile_rd2_in;

  always_comb begin
    w_result = 32'd0;
    case (ALUOp_in)
      2'b00: w_result = rfile_rd1_in + w_b;
      2'b01: w_result = rfile_rd1_in - w_b;
      2'b11: w_result = rfile_rd1_in | w_b;
      default: begin
        case (funct_in)
          6'h20, 6'h21: w_result = rfile_rd1_in + w_b;
          6'h22, 6'h23: w_result = rfile_rd1_in - w_b;
          6'h24: w_result = rfile_rd1_in & w_b;
          6'h25: w_result = rfile_rd1_in | w_b;
          6'h26: w_result = rfile_rd1_in ^ w_b;
          6'h27: w_result = ~(rfile_rd1_in | w_b);
          6'h2A: w_result = {31'd0, $signed(rfile_rd1_in) < $signed(w_b)};
          6'h2B: w_result = {31'd0, rfile_rd1_in < w_b};
          6'h00: w_result = rfile_rd2_in << shamt_in;
          6'h02: w_result = rfile_rd2_in >> shamt_in;
          6'h03: w_result = $signed(rfile_rd2_in) >>> shamt_in;
          6'h04: w_result = rfile_rd2_in << rfile_rd1_in[4:0];
          6'h06: w_result = rfile_rd2_in >> rfile_rd1_in[4:0];
          6'h07: w_result = $signed(rfile_rd2_in) >>> rfile_rd1_in[4:0];
          6'h10: w_result = r_hi;
          6'h12: w_result = r_lo;
          default: w_result = 32'd0;
        endcase
      end
    endcase
  end

  // Shift-add multiply step and restoring divide step on the working pair
  assign w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : 33'd0);
  assign w_rem_sh = {r_acc_hi, r_acc_lo[31]};
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_mcand};
  assign w_prod   = {r_acc_hi, r_acc_lo};

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_acc_hi_next  = r_acc_hi;
    w_acc_lo_next  = r_acc_lo;
    w_hi_next      = r_hi;
    w_lo_next      = r_lo;
    w_md_busy_next = r_md_busy;
    case (r_state)
      S_IDLE: begin
        if (w_md_start) begin
          w_state_next   = S_BUSY;
          w_count_next   = 6'd0;
          w_acc_hi_next  = 32'd0;
          w_acc_lo_next  = w_mag_a;
          w_md_busy_next = 1'b1;
        end
      end
      S_BUSY: begin
        if (r_is_div) begin
          if (!w_diff[33]) begin
            w_acc_hi_next = w_diff[31:0];
            w_acc_lo_next = {r_acc_lo[30:0], 1'b1};
          end else begin
            w_acc_hi_next = w_rem_sh[31:0];
            w_acc_lo_next = {r_acc_lo[30:0], 1'b0};
          end
        end else begin
          {w_acc_hi_next, w_acc_lo_next} = {w_sum, r_acc_lo[31:1]};
        end
        w_count_next = r_count + 6'd1;
        if (r_count == 6'(MD_CYCLES - 1))
          w_state_next = S_FIX;
      end
      S_FIX: begin
        if (r_is_div) begin
          // Zero divisor leaves |rs| in the remainder, so restoring the dividend sign yields rs
          w_hi_next = r_neg_hi ? -r_acc_hi : r_acc_hi;
          w_lo_next = (r_mcand == 32'd0) ? 32'hFFFF_FFFF :
                      (r_neg_lo ? -r_acc_lo : r_acc_lo);
        end else begin
          {w_hi_next, w_lo_next} = r_neg_lo ? -w_prod : w_prod;
        end
        w_state_next   = S_IDLE;
        w_md_busy_next = 1'b0;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_count   <= 6'd0;
      r_acc_hi  <= 32'd0;
      r_acc_lo  <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_mcand   <= 32'd0;
      r_is_div  <= 1'b0;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_md_busy <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_acc_hi  <= w_acc_hi_next;
      r_acc_lo  <= w_acc_lo_next;
      r_hi      <= w_hi_next;
      r_lo      <= w_lo_next;
      r_md_busy <= w_md_busy_next;
      if (r_state == S_IDLE && w_md_start) begin
        r_mcand  <= w_mag_b;
        r_is_div <= funct_in[1];
        r_neg_lo <= w_sa ^ w_sb;
        r_neg_hi <= w_sa;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MemtoReg_out   <= 1'b0;
      RegWrite_out   <= 1'b0;
      MemRead_out    <= 1'b0;
      MemWrite_out   <= 1'b0;
      alu_result_out <= 32'd0;
      wdata_out      <= 32'd0;
      wreg_out       <= 5'd0;
    end else if (stall) begin
      MemtoReg_out   <= 1'b0;
      RegWrite_out   <= 1'b0;
      MemRead_out    <= 1'b0;
      MemWrite_out   <= 1'b0;
      alu_result_out <= 32'd0;
      wdata_out      <= 32'd0;
      wreg_out       <= 5'd0;
    end else begin
      MemtoReg_out   <= MemtoReg_in;
      RegWrite_out   <= RegWrite_in;
      MemRead_out    <= MemRead_in;
      MemWrite_out   <= MemWrite_in;
      alu_result_out <= w_result;
      wdata_out      <= rfile_rd2_in;
      wreg_out       <= RegDst_in ? rd_in : rt_in;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is presented and compared after the capturing edge.
module tb_ex_stage;
  logic        clk, rst;
  logic        RegDst_in, ALUSrc_in, MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in;
  logic [1:0]  ALUOp_in;
  logic [5:0]  funct_in;
  logic [4:0]  shamt_in, rt_in, rd_in;
  logic [31:0] rfile_rd1_in, rfile_rd2_in, extend_immed_in;
  logic        MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out;
  logic [31:0] alu_result_out, wdata_out;
  logic [4:0]  wreg_out;
  logic        stall, md_busy;

  typedef struct {
    logic [31:0] res;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_left = 0;
  logic st;

  ex_stage #(.MD_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .RegDst_in(RegDst_in), .ALUSrc_in(ALUSrc_in),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .ALUOp_in(ALUOp_in), .funct_in(funct_in), .shamt_in(shamt_in),
    .rt_in(rt_in), .rd_in(rd_in),
    .rfile_rd1_in(rfile_rd1_in), .rfile_rd2_in(rfile_rd2_in),
    .extend_immed_in(extend_immed_in),
    .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .alu_result_out(alu_result_out), .wdata_out(wdata_out), .wreg_out(wreg_out),
    .stall(stall), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    RegDst_in = 0; ALUSrc_in = 0; MemtoReg_in = 0; RegWrite_in = 0;
    MemRead_in = 0; MemWrite_in = 0; ALUOp_in = 2'b00; funct_in = 6'h00;
    shamt_in = 0; rt_in = 0; rd_in = 0;
    rfile_rd1_in = 0; rfile_rd2_in = 0; extend_immed_in = 0;
  endtask

  task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic wr);
    clr();
    ALUOp_in = 2'b10; funct_in = f; rfile_rd1_in = a; rfile_rd2_in = b;
    RegDst_in = 1; rd_in = rd; RegWrite_in = wr;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".result"}, alu_result_out, 32'd0);
    chk({tag, ".wdata"}, wdata_out, 32'd0);
    chk({tag, ".wreg"}, {27'd0, wreg_out}, 32'd0);
    chk({tag, ".ctrl"}, {28'd0, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out}, 32'd0);
    chk({tag, ".md_busy"}, {31'd0, md_busy}, 32'd0);
  endtask

  // One clock: check stall, queue the expected EX/MEM content, clock, compare.
  task automatic cyc(input string tag, input logic [31:0] exp_res, output logic stalled);
    exp_t e;
    logic md, hilo, exp_stall;
    md   = (ALUOp_in == 2'b10) && (funct_in inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    hilo = md || ((ALUOp_in == 2'b10) && (funct_in inside {6'h10, 6'h12}));
    exp_stall = (busy_left > 0) && hilo;
    #1;
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
    if (exp_stall) e = '{32'd0, 32'd0, 5'd0, 4'd0};
    else e = '{exp_res, rfile_rd2_in, RegDst_in ? rd_in : rt_in,
               {MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in}};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (md && !exp_stall) busy_left = 33;
    else if (busy_left > 0) busy_left--;
    e = sb.pop_front();
    chk({tag, ".result"}, alu_result_out, e.res);
    chk({tag, ".wdata"}, wdata_out, e.wdata);
    chk({tag, ".wreg"}, {27'd0, wreg_out}, {27'd0, e.wreg});
    chk({tag, ".ctrl"}, {28'd0, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out},
        {28'd0, e.ctrl});
    chk({tag, ".md_busy"}, {31'd0, md_busy}, {31'd0, busy_left > 0});
    stalled = exp_stall;
  endtask

  // Re-present the current instruction until it leaves EX, with a cycle budget.
  task automatic until_issued(input string tag, input logic [31:0] exp_res);
    logic s;
    for (int i = 0; i < 40; i++) begin
      cyc(tag, exp_res, s);
      if (!s) return;
    end
    checks++;
    errors++;
    $display("FAIL %s.timeout: observed stalled after 40 cycles expected issue", tag);
  endtask

  initial begin
    clr();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset.stall", {31'd0, stall}, 32'd0);
    rst = 1;

    rtype(6'h20, 32'd5, 32'd7, 5'd9, 1'b1); rt_in = 5'd3;
    cyc("add", 32'd12, st);

    clr();
    ALUSrc_in = 1; rfile_rd1_in = 32'h100; extend_immed_in = 32'hFFFF_FFFC;
    MemRead_in = 1; MemtoReg_in = 1; RegWrite_in = 1; rt_in = 5'd4; rd_in = 5'd8;
    rfile_rd2_in = 32'hDEAD_BEEF;
    cyc("lw_addr", 32'h0000_00FC, st);

    clr();
    ALUOp_in = 2'b01; ALUSrc_in = 1; rfile_rd1_in = 32'd10; extend_immed_in = 32'd3;
    MemWrite_in = 1; rfile_rd2_in = 32'h1234_5678;
    cyc("sub_op", 32'd7, st);

    clr();
    ALUOp_in = 2'b11; ALUSrc_in = 1; rfile_rd1_in = 32'hF0; extend_immed_in = 32'h0F;
    cyc("ori", 32'hFF, st);

    rtype(6'h03, 32'd0, 32'h8000_0000, 5'd2, 1'b1); shamt_in = 5'd4;
    cyc("sra", 32'hF800_0000, st);
    rtype(6'h02, 32'd0, 32'h8000_0000, 5'd2, 1'b1); shamt_in = 5'd31;
    cyc("srl", 32'd1, st);
    rtype(6'h04, 32'h24, 32'd1, 5'd2, 1'b1);
    cyc("sllv", 32'h10, st);
    rtype(6'h26, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd2, 1'b1);
    cyc("xor", 32'hF00F_F00F, st);
    rtype(6'h27, 32'h0000_FFFF, 32'h00FF_0000, 5'd2, 1'b1);
    cyc("nor", 32'hFF00_0000, st);
    rtype(6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1);
    cyc("sltu", 32'd0, st);
    rtype(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1);
    cyc("slt", 32'd1, st);
    rtype(6'h3F, 32'd1, 32'd1, 5'd2, 1'b1);
    cyc("bad_funct", 32'd0, st);

    rtype(6'h18, -32'sd3, 32'd7, 5'd0, 1'b0);
    cyc("mult", 32'd0, st);
    rtype(6'h21, 32'd1, 32'd2, 5'd6, 1'b1);
    cyc("add_busy", 32'd3, st);
    rtype(6'h12, 32'd0, 32'd0, 5'd10, 1'b1);
    until_issued("mult.mflo", 32'hFFFF_FFEB);
    rtype(6'h10, 32'd0, 32'd0, 5'd11, 1'b1);
    cyc("mult.mfhi", 32'hFFFF_FFFF, st);

    rtype(6'h1A, -32'sd7, 32'd2, 5'd0, 1'b0);
    cyc("div", 32'd0, st);
    rtype(6'h12, 32'd0, 32'd0, 5'd10, 1'b1);
    until_issued("div.mflo", 32'hFFFF_FFFD);
    rtype(6'h10, 32'd0, 32'd0, 5'd11, 1'b1);
    cyc("div.mfhi", 32'hFFFF_FFFF, st);

    rtype(6'h1B, 32'h1234, 32'd0, 5'd0, 1'b0);
    cyc("divu0", 32'd0, st);
    rtype(6'h10, 32'd0, 32'd0, 5'd11, 1'b1);
    until_issued("divu0.mfhi", 32'h1234);
    rtype(6'h12, 32'd0, 32'd0, 5'd10, 1'b1);
    cyc("divu0.mflo", 32'hFFFF_FFFF, st);

    rtype(6'h19, 32'h55, 32'h66, 5'd0, 1'b0);
    cyc("multu_abort", 32'd0, st);
    for (int i = 0; i < 10; i++) begin
      rtype(6'h21, 32'd0, 32'd0, 5'd0, 1'b0);
      cyc("nop_busy", 32'd0, st);
    end
    rtype(6'h10, 32'd0, 32'd0, 5'd11, 1'b1);
    #2;
    rst = 0;
    busy_left = 0;
    #1;
    chk_zero("midreset");
    chk("midreset.stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1;
    cyc("post_reset.mfhi", 32'd0, st);
    rtype(6'h12, 32'd0, 32'd0, 5'd10, 1'b1);
    cyc("post_reset.mflo", 32'd0, st);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage plus EX/MEM pipeline register. Sits directly downstream of the ID/EX register and consumes its control, operand and field outputs.
- Performs ALU operations, shifts and an iterative 32-cycle multiply/divide into HI/LO.
- Registers results and the M/W control bits toward the MEM stage.
- Raises a stall to the hazard logic when an instruction in EX needs the busy multiply/divide unit or its results.

Parameters:
MD_CYCLES, 32, iteration count of the multiply/divide unit; must be 32.

Ports:
clk  in  1  clock, rising-edge active
rst  in  1  asynchronous, active-low reset
RegDst_in  in  1  1: destination is rd, 0: destination is rt
ALUSrc_in  in  1  1: operand B is extend_immed_in, 0: rfile_rd2_in
MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in  in  1 each  W/M control bits from ID/EX
ALUOp_in  in  2  00 add, 01 sub, 10 R-type (funct), 11 or
funct_in  in  6  R-type function field
shamt_in  in  5  shift amount
rt_in, rd_in  in  5 each  register numbers
rfile_rd1_in, rfile_rd2_in  in  32 each  rs and rt operand values
extend_immed_in  in  32  sign-extended immediate
MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out  out  1 each  registered control bits
alu_result_out  out  32  registered result or memory address
wdata_out  out  32  registered rfile_rd2_in (store data)
wreg_out  out  5  registered destination register
stall  out  1  combinational; hold PC, IF/ID and ID/EX this cycle
md_busy  out  1  registered; multiply/divide in progress

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, HI=LO=0, FSM to IDLE, counter 0. A reset mid-operation aborts the operation with no HI/LO update.
- Operand B = ALUSrc_in ? extend_immed_in : rfile_rd2_in.
- ALUOp 00: A+B. ALUOp 01: A-B. ALUOp 11: A|B. All arithmetic wraps at 32 bits; no overflow trap.
- R-type funct decode:
  - 20/21 add: A+B. 22/23 sub: A-B.
  - 24 and, 25 or, 26 xor, 27 nor.
  - 2A slt: signed compare, result 1 or 0. 2B sltu: unsigned compare, result 1 or 0.
  - 00 sll, 02 srl, 03 sra: shift rd2 by shamt.
  - 04 sllv, 06 srlv, 07 srav: shift rd2 by rd1[4:0].
  - 10 mfhi: result HI. 12 mflo: result LO.
  - 18 mult, 19 multu, 1A div, 1B divu: start the multiply/divide unit; result 0.
  - Any other funct: result 0.
- wreg = RegDst_in ? rd_in : rt_in.
- Normal cycle (stall=0): the EX/MEM registers capture the result, rfile_rd2_in, wreg and the four M/W control bits. Latency is 1 cycle.
- Multiply/divide FSM, states IDLE, BUSY, FIX:
  - IDLE -> BUSY: when an md op is in EX and stall=0. Latch operand magnitudes (signed ops take absolute values), the result signs and the op type; counter=0; md_busy=1 next cycle.
  - BUSY: one shift-add step (mult) or one restoring-subtract step (div) per cycle. After MD_CYCLES steps, go to FIX.
  - FIX: apply sign correction and write HI/LO at the end of this cycle, then go to IDLE; md_busy=0 next cycle. The total from issue edge to HI/LO valid is 33 cycles.
  - mult/multu result: HI:LO = 64-bit product.
  - div/divu result: LO = quotient, HI = remainder. The remainder takes the sign of the dividend; the quotient is negative iff the operand signs differ.
  - Divide by zero: HI = rs, LO = 32'hFFFFFFFF, sign correction skipped.
- The md instruction itself enters EX/MEM with its control bits unchanged; the decoder supplies RegWrite=0 for it.
- stall = md_busy AND (instruction in EX is mfhi, mflo, mult, multu, div or divu).
  - While stall=1, EX/MEM captures a bubble: all four control bits 0, data fields 0. The upstream stages hold, so the same instruction is re-presented.
  - In FIX, md_busy is still 1, so stall holds. The first cycle with md_busy=0, mfhi/mflo reads the new HI/LO.
- Instructions that do not touch HI/LO proceed without stall while the unit is BUSY.

Test Plan:
- Reset release; ALUOp=10, funct=20, rd1=5, rd2=7, RegDst=1, rd=9, RegWrite=1 -> next edge: alu_result_out=12, wreg_out=9, RegWrite_out=1.
- ALUOp=00, ALUSrc=1, rd1=0x100, imm=0xFFFFFFFC, MemRead=1, rt=4 -> alu_result_out=0xFC, wreg_out=4, MemRead_out=1. Also: funct=03, shamt=4, rd2=0x80000000 -> 0xF8000000.
- mult rd1=-3, rd2=7 followed immediately by mflo -> stall=1 and EX/MEM bubbles until HI/LO are written. The mflo then gives LO=0xFFFFFFEB, and mfhi gives 0xFFFFFFFF. An unrelated add issued during BUSY completes without stall.
- div rd1=-7, rd2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu by 0 with rd1=0x1234 -> HI=0x1234, LO=0xFFFFFFFF.
- Assert rst at BUSY cycle 10 -> all outputs 0, md_busy=0, stall=0, HI/LO=0. A subsequent mfhi returns 0 without stall.
- sltu with rd1=0xFFFFFFFF, rd2=1 -> 0. slt with the same operands -> 1.
